// File: rtl/sha_msg_feeder.sv
// Byte-stream front end for a single-block SHA-256 core: pads a 1-55 byte message into
// one 512-bit block, launches the core, and hands its digest out on a valid/ready port.
module sha_msg_feeder #(
  parameter int unsigned WAIT_LIMIT = 127
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] core_msg,
  output logic         core_start,
  input  logic [255:0] core_hash,
  input  logic         core_valid,
  output logic [255:0] hash_out,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic         len_err,
  output logic         tmo_err
);

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_PAD     = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESULT  = 3'd4
  } state_e;

  localparam logic [8:0] LIMIT_C = 9'(WAIT_LIMIT);

  state_e         state_q;
  logic [511:0]   block_q;
  logic [5:0]     count_q;
  logic [5:0]     count_d;
  logic [5:0]     len_q;
  logic           ovf_q;
  logic [7:0]     wait_q;
  logic [255:0]   hash_q;
  logic           in_ready_q;
  logic           start_q;
  logic           hvalid_q;
  logic           len_err_q;
  logic           tmo_err_q;
  logic           accept_s;
  logic           ovf_s;
  logic [8:0]     wr_base_s;

  // Byte lane n lives at [511-8n -: 8]; returns the low bit index of that lane.
  function automatic logic [8:0] lane_base(input logic [5:0] lane);
    return 9'd504 - {lane, 3'b000};
  endfunction

  assign accept_s  = in_valid & in_ready_q;
  assign ovf_s     = ovf_q | (count_q >= 6'd55);
  assign wr_base_s = lane_base((state_q == ST_PAD) ? len_q : count_q);

  // Saturating byte counter next value.
  always_comb begin
    count_d = count_q;
    if (count_q < 6'd56) begin
      count_d = count_q + 6'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Main control FSM with all outputs registered.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_COLLECT;
      block_q    <= '0;
      count_q    <= 6'd0;
      len_q      <= 6'd0;
      ovf_q      <= 1'b0;
      wait_q     <= 8'd0;
      hash_q     <= '0;
      in_ready_q <= 1'b1;
      start_q    <= 1'b0;
      hvalid_q   <= 1'b0;
      len_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      len_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          if (accept_s) begin
            if (count_q < 6'd55) block_q[wr_base_s +: 8] <= in_data;
            if (in_last && ovf_s) begin
              // Over-long message: drop everything collected so far.
              len_err_q <= 1'b1;
              block_q   <= '0;
              count_q   <= 6'd0;
              ovf_q     <= 1'b0;
            end else if (in_last) begin
              len_q      <= count_q + 6'd1;
              count_q    <= count_d;
              state_q    <= ST_PAD;
              in_ready_q <= 1'b0;
            end else begin
              count_q <= count_d;
              ovf_q   <= ovf_s;
            end
          end
        end
        ST_PAD: begin
          block_q[wr_base_s +: 8] <= 8'h80;
          block_q[63:0]           <= {55'd0, len_q, 3'b000};
          wait_q                  <= 8'd0;
          start_q                 <= 1'b1;
          state_q                 <= ST_START;
        end
        ST_START: begin
          wait_q  <= 8'd1;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_valid) begin
            hash_q   <= core_hash;
            hvalid_q <= 1'b1;
            state_q  <= ST_RESULT;
          end else if (({1'b0, wait_q} + 9'd1) >= LIMIT_C) begin
            tmo_err_q  <= 1'b1;
            block_q    <= '0;
            count_q    <= 6'd0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= ST_COLLECT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        ST_RESULT: begin
          if (hash_ready) begin
            hvalid_q   <= 1'b0;
            block_q    <= '0;
            count_q    <= 6'd0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= ST_COLLECT;
          end
        end
        default: begin
          block_q    <= '0;
          count_q    <= 6'd0;
          ovf_q      <= 1'b0;
          hvalid_q   <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= ST_COLLECT;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign core_msg   = block_q;
  assign core_start = start_q;
  assign hash_out   = hash_q;
  assign hash_valid = hvalid_q;
  assign len_err    = len_err_q;
  assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_sha_msg_feeder.sv
// Randomized bench for sha_msg_feeder; the bench plays the hash core with a mock digest
// derived from the block it was started with, and predicts blocks from the padding rules.
module tb_sha_msg_feeder;
  localparam int LIMIT = 10;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'd0, 64'h18};

  typedef logic [7:0] msg_t [$];

  logic         clk, clr, in_valid, in_last, in_ready, core_start, core_valid;
  logic         hash_valid, hash_ready, len_err, tmo_err;
  logic [7:0]   in_data;
  logic [511:0] core_msg, obs_blk;
  logic [255:0] core_hash, hash_out, obs_hash;
  int n_tests, n_fail, t_last, starts, len_errs;
  int cyc = 0;
  bit gap_en;

  sha_msg_feeder #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .core_msg(core_msg), .core_start(core_start),
    .core_hash(core_hash), .core_valid(core_valid), .hash_out(hash_out),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .len_err(len_err), .tmo_err(tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (core_start) starts <= starts + 1;
    if (len_err) len_errs <= len_errs + 1;
  end

  // Padded block as the rules describe it: bytes, 0x80, zeros, bit length.
  function automatic logic [511:0] ref_block(input msg_t m);
    logic [511:0] b;
    int l;
    b = '0;
    l = m.size();
    for (int i = 0; i < l; i++) b[511 - 8 * i -: 8] = m[i];
    b[511 - 8 * l -: 8] = 8'h80;
    b[63:0] = 64'(l * 8);
    return b;
  endfunction

  // Mock core: true digest for "abc", otherwise a fixed scramble of the block.
  function automatic logic [255:0] fake_hash(input logic [511:0] b);
    if (b == ABC_BLK) return ABC_DIGEST;
    return b[511:256] ^ {b[255:0]} ^ {8{32'h5a3c96e1}};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32 * i +: 32] = $urandom();
    return h;
  endfunction

  function automatic msg_t rand_msg(input int len);
    msg_t m;
    for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
    return m;
  endfunction

  task automatic feed(input msg_t m);
    for (int i = 0; i < m.size(); i++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = m[i];
      in_last  = (i == m.size() - 1);
      if (in_last) t_last = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  // One full transaction: feed, core start timing, block, digest, result handshake.
  task automatic do_block(input msg_t m, input int lat, input int hold, input string tag);
    logic [511:0] exp_b, cap;
    logic [255:0] exp_h;
    int s;
    bit got;
    exp_b = ref_block(m);
    exp_h = fake_hash(exp_b);
    hash_ready = (hold == 0);
    feed(m);
    got = 1'b0;
    s = -1;
    for (int k = 0; k < 8 && !got; k++) begin
      if (core_start) begin got = 1'b1; s = cyc; end
      else @(negedge clk);
    end
    n_tests++;
    if (s != t_last + 2) begin
      n_fail++; $display("FAIL %s start_cycle: got %0d want %0d", tag, s, t_last + 2);
    end
    n_tests++;
    if (core_msg !== exp_b) begin
      n_fail++; $display("FAIL %s block: got %h want %h", tag, core_msg, exp_b);
    end
    if (!got) return;
    cap = core_msg;
    obs_blk = core_msg;
    repeat (lat) @(negedge clk);
    n_tests++;
    if (core_msg !== cap) begin
      n_fail++; $display("FAIL %s block_held: got %h want %h", tag, core_msg, cap);
    end
    core_valid = 1'b1;
    core_hash  = fake_hash(cap);
    @(negedge clk);
    core_valid = 1'b0;
    core_hash  = rand256();
    obs_hash   = hash_out;
    n_tests++;
    if ({hash_valid, hash_out} !== {1'b1, exp_h}) begin
      n_fail++; $display("FAIL %s digest: got v=%b %h want v=1 %h", tag, hash_valid, hash_out, exp_h);
    end
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      n_tests++;
      if ({hash_valid, in_ready, hash_out} !== {2'b10, exp_h}) begin
        n_fail++;
        $display("FAIL %s hold: got v=%b rdy=%b %h want v=1 rdy=0 %h", tag, hash_valid, in_ready, hash_out, exp_h);
      end
    end
    in_valid   = 1'b0;
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0;
    n_tests++;
    if ({hash_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", tag, hash_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({in_ready, core_start, hash_valid, len_err, tmo_err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 10000", {in_ready, core_start, hash_valid, len_err, tmo_err});
    end
    n_tests++;
    if (core_msg !== 512'd0) begin n_fail++; $display("FAIL reset_block: got %h want 0", core_msg); end
    n_tests++;
    if (hash_out !== 256'd0) begin n_fail++; $display("FAIL reset_hash: got %h want 0", hash_out); end
  endtask

  task automatic test_abc();
    msg_t m;
    m = {8'h61, 8'h62, 8'h63};
    do_block(m, 5, 0, "abc");
    n_tests++;
    if (obs_blk !== ABC_BLK) begin n_fail++; $display("FAIL abc_block_lit: got %h want %h", obs_blk, ABC_BLK); end
    n_tests++;
    if (obs_hash !== ABC_DIGEST) begin n_fail++; $display("FAIL abc_digest_lit: got %h want %h", obs_hash, ABC_DIGEST); end
  endtask

  task automatic test_max_len();
    msg_t m;
    logic [439:0] a;
    for (int i = 0; i < 55; i++) m.push_back(8'h61);
    for (int i = 0; i < 55; i++) a[8 * i +: 8] = 8'h61;
    do_block(m, LIMIT - 1, 3, "max55");
    n_tests++;
    if ({obs_blk[511:72], obs_blk[71:64], obs_blk[63:0]} !== {a, 8'h80, 64'h1B8}) begin
      n_fail++; $display("FAIL max55_lit: got %h", obs_blk);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      do_block(rand_msg($urandom_range(1, 55)), $urandom_range(1, LIMIT - 1), $urandom_range(0, 4), "rand");
  endtask

  task automatic test_overflow();
    int s0, e0;
    msg_t m;
    s0 = starts;
    e0 = len_errs;
    feed(rand_msg(56));
    n_tests++;
    if (len_err !== 1'b1) begin n_fail++; $display("FAIL ovf56_pulse: got %b want 1", len_err); end
    @(negedge clk);
    n_tests++;
    if ({len_err, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL ovf56_after: got err=%b rdy=%b want err=0 rdy=1", len_err, in_ready);
    end
    feed(rand_msg(60));
    repeat (4) @(negedge clk);
    n_tests++;
    if (starts != s0 || len_errs != e0 + 2) begin
      n_fail++; $display("FAIL ovf_counts: got starts+%0d errs+%0d want +0 +2", starts - s0, len_errs - e0);
    end
    m = {8'h61, 8'h62, 8'h63};
    do_block(m, 4, 1, "abc_after_ovf");
    n_tests++;
    if (obs_hash !== ABC_DIGEST) begin n_fail++; $display("FAIL ovf_abc: got %h want %h", obs_hash, ABC_DIGEST); end
  endtask

  task automatic test_timeout();
    int s, t_seen, n_seen;
    logic rdy;
    feed(rand_msg($urandom_range(1, 55)));
    s = -1;
    for (int k = 0; k < 8 && s < 0; k++) begin
      if (core_start) s = cyc;
      else @(negedge clk);
    end
    t_seen = -1;
    n_seen = 0;
    rdy = 1'b0;
    for (int k = 0; k < LIMIT + 3; k++) begin
      @(negedge clk);
      if (tmo_err) begin n_seen++; if (t_seen < 0) t_seen = cyc; end
      if (cyc == s + LIMIT) rdy = in_ready;
    end
    n_tests++;
    if (s < 0 || t_seen != s + LIMIT || n_seen != 1) begin
      n_fail++; $display("FAIL tmo_timing: got cyc %0d count %0d want cyc %0d count 1", t_seen, n_seen, s + LIMIT);
    end
    n_tests++;
    if ({rdy, hash_valid} !== 2'b10) begin
      n_fail++; $display("FAIL tmo_collect: got rdy=%b v=%b want rdy=1 v=0", rdy, hash_valid);
    end
  endtask

  task automatic test_back_to_back();
    gap_en = 1'b0;
    do_block(rand_msg($urandom_range(1, 55)), 2, 0, "b2b_a");
    do_block(rand_msg($urandom_range(1, 55)), 1, 0, "b2b_b");
    gap_en = 1'b1;
  endtask

  task automatic test_reset_wait();
    msg_t m;
    feed(rand_msg($urandom_range(1, 55)));
    repeat (5) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, core_start, hash_valid, len_err, tmo_err} !== 5'b10000 || core_msg !== 512'd0 || hash_out !== 256'd0) begin
      n_fail++;
      $display("FAIL rst_wait_outputs: got flags %b block_zero=%b hash_zero=%b want 10000 1 1",
               {in_ready, core_start, hash_valid, len_err, tmo_err}, core_msg == 512'd0, hash_out == 256'd0);
    end
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    core_valid = 1'b1;
    core_hash  = rand256();
    @(negedge clk);
    core_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({hash_valid, in_ready, hash_out} !== {2'b01, 256'd0}) begin
      n_fail++; $display("FAIL rst_stray_valid: got v=%b rdy=%b %h want v=0 rdy=1 0", hash_valid, in_ready, hash_out);
    end
    m = {8'h61, 8'h62, 8'h63};
    do_block(m, 6, 0, "abc_after_rst");
    n_tests++;
    if (obs_hash !== ABC_DIGEST) begin n_fail++; $display("FAIL rst_abc: got %h want %h", obs_hash, ABC_DIGEST); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; starts = 0; len_errs = 0; t_last = 0;
    gap_en = 1'b1;
    clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    core_valid = 1'b0; core_hash = '0; hash_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_abc();
    test_max_len();
    test_random();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
